// File: rtl/coin_token_encoder_if.sv
// coin_token_encoder_if: coin sensor inputs, hold and amount-code outputs of the coin token encoder
interface coin_token_encoder_if #(
  parameter int DEPTH = 4
);
  logic                     coin5_raw;
  logic                     coin10_raw;
  logic                     hold;
  logic [4:0]               amt;
  logic                     reject;
  logic [$clog2(DEPTH):0]   level;
  modport master (output coin5_raw, coin10_raw, hold, input amt, reject, level);
  modport slave (input coin5_raw, coin10_raw, hold, output amt, reject, level);
endinterface

// File: rtl/coin_token_encoder.sv
// coin_token_encoder: debounces coin sensors, queues coin events and emits gap-separated amount codes
module coin_token_encoder #(
  parameter int DEPTH      = 4,
  parameter int DEB_CYCLES = 4,
  parameter int GAP        = 1
) (
  input logic               clk,
  input logic               rst,
  coin_token_encoder_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  logic [1:0]       s1_q, s2_q, deb_q, debp_q;
  logic [CW-1:0]    cnt_q [2];
  logic [1:0]       ev;
  logic             pend_q, push, push_ten, pop, full, push_ok, rej_q;
  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wp_q, rp_q;
  logic [LW-1:0]    lvl_q;
  logic [GW-1:0]    gap_q;
  logic [4:0]       amt_q;
  // bit 1 is the 10-unit line, bit 0 the 5-unit line
  assign ev       = deb_q & ~debp_q;
  assign push     = pend_q | ev[0] | ev[1];
  assign push_ten = ~pend_q & ev[1];
  assign full     = lvl_q == LW'(DEPTH);
  assign pop      = (lvl_q != '0) & ~bus.hold & (gap_q == '0);
  assign push_ok  = push & (~full | pop);
  assign bus.amt    = amt_q;
  assign bus.reject = rej_q;
  assign bus.level  = lvl_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      deb_q  <= '0;
      debp_q <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      pend_q <= 1'b0;
      mem_q  <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      lvl_q  <= '0;
      gap_q  <= '0;
      amt_q  <= '0;
      rej_q  <= 1'b0;
    end else begin
      s1_q   <= {bus.coin10_raw, bus.coin5_raw};
      s2_q   <= s1_q;
      debp_q <= deb_q;
      for (int i = 0; i < 2; i++)
        if (s2_q[i] == deb_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == DEB_LAST) begin
          deb_q[i] <= s2_q[i];
          cnt_q[i] <= '0;
        end else cnt_q[i] <= cnt_q[i] + 1'b1;
      // a simultaneous 5-unit event waits one cycle behind the 10-unit coin
      pend_q <= pend_q ? ev[0] : (ev[1] & ev[0]);
      if (push_ok) begin
        mem_q[wp_q] <= push_ten;
        wp_q        <= wp_q + 1'b1;
      end
      if (pop) rp_q <= rp_q + 1'b1;
      lvl_q <= lvl_q + LW'(push_ok) - LW'(pop);
      rej_q <= push & full & ~pop;
      gap_q <= pop ? GW'(GAP) : (gap_q == '0 ? '0 : gap_q - 1'b1);
      amt_q <= pop ? (mem_q[rp_q] ? 5'd10 : 5'd5) : 5'd0;
    end
  end
endmodule

// File: tb/tb_coin_token_encoder.sv
// tb_coin_token_encoder: scoreboard bench for the coin token encoder
module tb_coin_token_encoder;
  localparam int DEPTH = 4, DEB = 4, GAP = 1;
  logic clk = 1'b0, rst = 1'b0;
  int tests = 0, fails = 0, npulse = 0, nrej = 0;
  logic [4:0] exp_q[$];
  logic [4:0] mon_e;
  coin_token_encoder_if #(.DEPTH(DEPTH)) bus();
  coin_token_encoder #(.DEPTH(DEPTH), .DEB_CYCLES(DEB), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (rst) begin
    if (bus.reject) nrej++;
    if (bus.amt != 5'd0) begin
      npulse++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: amt=%0d, required no emission", bus.amt);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.amt !== mon_e) begin
          fails++;
          $display("FAIL sb_code: amt=%0d, required %0d", bus.amt, mon_e);
        end
      end
    end
  end
  task automatic coin(input bit ten, input bit accepted);
    @(posedge clk); #1;
    if (ten) bus.coin10_raw = 1'b1; else bus.coin5_raw = 1'b1;
    if (accepted) exp_q.push_back(ten ? 5'd10 : 5'd5);
    repeat (10) @(posedge clk);
    #1 bus.coin10_raw = 1'b0; bus.coin5_raw = 1'b0;
    repeat (10) @(posedge clk);
  endtask
  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d codes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_reset;
    bus.coin5_raw = 1'b0; bus.coin10_raw = 1'b0; bus.hold = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      tests++;
      if ({bus.amt, bus.reject, bus.level} !== 9'd0) begin
        fails++;
        $display("FAIL reset_idle: amt=%0d reject=%0d level=%0d, required all 0", bus.amt, bus.reject, bus.level);
      end
    end
  endtask
  task automatic test_single_coin5;
    int p0 = npulse, first = -1;
    @(posedge clk); #1 bus.coin5_raw = 1'b1;
    exp_q.push_back(5'd5);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.amt != 5'd0 && first < 0) first = c;
      if (c == 9) bus.coin5_raw = 1'b0;
    end
    tests += 3;
    if (first !== 2 + DEB + 2) begin fails++; $display("FAIL single_latency: pulse at cycle %0d, required %0d", first, 2 + DEB + 2); end
    if (npulse - p0 !== 1) begin fails++; $display("FAIL single_count: %0d pulse cycles, required 1", npulse - p0); end
    if (bus.level !== 3'd0) begin fails++; $display("FAIL single_level: level=%0d, required 0", bus.level); end
    drain("single");
  endtask
  task automatic test_bounce;
    int p0 = npulse;
    exp_q.push_back(5'd10);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1 bus.coin10_raw = ((c / 2) % 2 == 0);
    end
    @(posedge clk); #1 bus.coin10_raw = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus.coin10_raw = 1'b0;
    repeat (20) @(posedge clk);
    tests++;
    if (npulse - p0 !== 1) begin fails++; $display("FAIL bounce_count: %0d pulse cycles, required 1", npulse - p0); end
    drain("bounce");
  endtask
  task automatic test_both;
    int pos[$];
    logic [4:0] val[$];
    int peak = 0;
    @(posedge clk); #1 bus.coin5_raw = 1'b1; bus.coin10_raw = 1'b1;
    exp_q.push_back(5'd10);
    exp_q.push_back(5'd5);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.amt != 5'd0) begin pos.push_back(c); val.push_back(bus.amt); end
      if (int'(bus.level) > peak) peak = int'(bus.level);
      if (c == 9) begin bus.coin5_raw = 1'b0; bus.coin10_raw = 1'b0; end
    end
    tests += 3;
    if (pos.size() !== 2) begin
      fails++;
      $display("FAIL both_count: %0d pulses, required 2", pos.size());
    end else begin
      if ({val[0], val[1]} !== {5'd10, 5'd5}) begin fails++; $display("FAIL both_order: %0d,%0d, required 10,5", val[0], val[1]); end
      if (pos[1] - pos[0] !== GAP + 1) begin fails++; $display("FAIL both_gap: spacing %0d, required %0d", pos[1] - pos[0], GAP + 1); end
    end
    tests++;
    if (peak < 1 || peak > 2) begin fails++; $display("FAIL both_peak: level peak %0d, required 1..2", peak); end
    drain("both");
  endtask
  task automatic test_hold_full;
    int p0 = npulse, r0 = nrej;
    int pos[$];
    bus.hold = 1'b1;
    for (int k = 0; k < 6; k++) coin(1'b0, k < DEPTH);
    tests += 3;
    if (bus.level !== 3'(DEPTH)) begin fails++; $display("FAIL hold_level: level=%0d, required %0d", bus.level, DEPTH); end
    if (nrej - r0 !== 2) begin fails++; $display("FAIL hold_reject: %0d reject cycles, required 2", nrej - r0); end
    if (npulse - p0 !== 0) begin fails++; $display("FAIL hold_emit: %0d pulses under hold, required 0", npulse - p0); end
    @(posedge clk); #1 bus.hold = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.amt != 5'd0) pos.push_back(c);
    end
    tests += 2;
    if (pos.size() !== DEPTH) begin
      fails++;
      $display("FAIL hold_release_count: %0d pulses, required %0d", pos.size(), DEPTH);
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        tests++;
        if (pos[k] - pos[k-1] !== GAP + 1) begin fails++; $display("FAIL hold_spacing: %0d, required %0d", pos[k] - pos[k-1], GAP + 1); end
      end
    end
    if (bus.level !== 3'd0) begin fails++; $display("FAIL hold_empty: level=%0d, required 0", bus.level); end
    drain("hold");
  endtask
  task automatic test_reset_mid;
    int n = 0, p0;
    bus.hold = 1'b1;
    for (int k = 0; k < 3; k++) coin(1'b0, 1'b1);
    @(posedge clk); #1 bus.hold = 1'b0;
    do begin @(negedge clk); n++; end while (bus.amt != 5'd5 && n < 20);
    tests++;
    if (bus.amt !== 5'd5 || bus.level !== 3'd2) begin
      fails++;
      $display("FAIL mid_setup: amt=%0d level=%0d, required 5 and 2", bus.amt, bus.level);
    end
    #2 rst = 1'b0;
    #1;
    tests += 2;
    if (bus.amt !== 5'd0) begin fails++; $display("FAIL mid_amt: amt=%0d, required 0", bus.amt); end
    if (bus.level !== 3'd0) begin fails++; $display("FAIL mid_level: level=%0d, required 0", bus.level); end
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    p0 = npulse;
    repeat (40) @(posedge clk);
    tests++;
    if (npulse - p0 !== 0) begin fails++; $display("FAIL mid_after: %0d pulses after release, required 0", npulse - p0); end
  endtask
  initial begin
    test_reset;
    test_single_coin5;
    test_bounce;
    test_both;
    test_hold_full;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule

// File: doc/coin_token_encoder.md
Name: coin_token_encoder

Overview:
- Upstream stage of the coffee vending FSM: converts raw coin-slot sensor lines (5-unit and 10-unit coins) into the 5-bit amount codes the vending FSM samples every clock.
- Synchronises and debounces each sensor, detects coin insertions, buffers them in a small FIFO, and emits them as one-cycle amount codes separated by idle (zero) cycles.
- Honours a hold input so no coin is presented while the vending FSM is dispensing and ignoring its input.

Parameters:
- DEPTH, 4, coin FIFO depth in entries; must be a power of two and at least 2.
- DEB_CYCLES, 4, consecutive stable synchronised samples required before a debounced level changes; at least 1.
- GAP, 1, minimum number of amt==0 cycles after every emitted code; at least 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- coin5_raw  input  1  asynchronous sensor line, high while a 5-unit coin passes.
- coin10_raw  input  1  asynchronous sensor line, high while a 10-unit coin passes.
- hold  input  1  synchronous; 1 blocks popping and emission (driven while the vending FSM dispenses).
- amt  output  5  amount code to vending FSM: 5'b00000 idle, 5'b00101 = 5, 5'b01010 = 10.
- reject  output  1  one-cycle pulse when a detected coin is dropped because the FIFO is full.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0, asynchronous): amt=0, reject=0, level=0. Synchroniser flops, debounced levels, debounce counters, pending flag, FIFO pointers and gap counter are all cleared. Reset mid-emission forces amt=0 immediately. No coin is emitted after release until a new insertion is debounced.
- Sync: each raw line passes through a 2-flop synchroniser.
- Debounce (per line): the counter resets whenever the synchronised value equals the debounced level, and otherwise increments. When it reaches DEB_CYCLES, the debounced level takes the synchronised value and the counter clears. The minimum delay from a raw edge to a debounced edge is 2+DEB_CYCLES cycles.
- Event: a rising edge of a debounced level is one coin event. Falling edges produce no event.
- Push arbitration:
  - If a coin10 and a coin5 event occur in the same cycle, coin10 is pushed that cycle and coin5 is latched in a pending flag and pushed the next cycle.
  - A pending coin5 has priority over any new event; a new event cannot coincide with it given debounce.
- FIFO:
  - Push and pop are permitted in the same cycle, including when the FIFO is full (occupancy unchanged, push accepted).
  - Push when full without a simultaneous pop: the coin is dropped, reject=1 for exactly that following cycle, and level stays DEPTH.
  - Pointers wrap modulo DEPTH.
- Emission: a pop occurs in cycle t when level>0, hold=0 and the gap counter is 0.
  - In cycle t+1, amt equals the popped code (registered, one cycle only).
  - From t+2, amt=0 for at least GAP cycles. The gap counter loads GAP on pop and decrements to 0.
  - The latency from a push into an empty FIFO to amt valid is 2 cycles when hold=0.
- hold: sampled in the pop decision only. Asserting hold never truncates a code already on amt. The gap counter keeps decrementing while hold=1.
- Empty: amt=0. No underflow; level never wraps below 0.
- amt never carries any value other than 0, 5 or 10.

Test Plan:
- Reset then idle 20 cycles -> amt=0, reject=0, level=0 throughout.
- coin5_raw high for 10 cycles -> exactly one amt=5'b00101 pulse of 1 cycle, the pulse 2+DEB_CYCLES+2 cycles after the raw rise (8 with defaults), level returns to 0.
- coin10_raw bounce: toggle high/low every 2 cycles for 8 cycles, then stable high for 10 -> exactly one amt=5'b01010 pulse.
- Both raw lines rise in the same cycle, stable 10 cycles -> amt sequence 10, 0, 5 (GAP=1), level peaks at 1 or 2.
- hold=1, insert six 5-unit coins (DEPTH=4) -> level saturates at 4, two reject pulses, amt=0. Release hold -> four amt=5 pulses each separated by one 0 cycle.
- Assert rst mid-sequence while amt=5 with level=2 -> amt=0 in the same cycle, level=0, and no further emissions after release.
